// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ requesters.
// The granted word is latched and sent LSB byte first via tx_start/tx_din, pacing on tx_done_tick.
module uart_tx_scheduler #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_BITS  = 8,
    parameter int WORD_BYTES = 4,
    localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ*WORD_BYTES*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]                    req_ack,
    output logic [NUM_REQ-1:0]                    word_done,
    output logic [GW-1:0]                         grant_id,
    output logic                                  busy,
    output logic                                  tx_start,
    output logic [DATA_BITS-1:0]                  tx_din,
    input  logic                                  tx_done_tick
);

    localparam int W  = WORD_BYTES * DATA_BITS;
    localparam int CW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [GW-1:0]       r_last;
    logic [GW-1:0]       r_grant;
    logic [W-1:0]        r_shift;
    logic [CW-1:0]       r_cnt;
    logic [NUM_REQ-1:0]  r_ack;
    logic [NUM_REQ-1:0]  r_done;
    logic [GW-1:0]       w_pick;
    logic [GW-1:0]       w_pick_hi;
    logic [GW-1:0]       w_pick_lo;
    logic                w_any_hi;
    logic                w_last_byte;

    // Lowest valid index above r_last wins; otherwise wrap to the lowest valid index at or below it.
    always_comb begin
        w_pick_hi = '0;
        w_pick_lo = '0;
        w_any_hi  = 1'b0;
        for (int unsigned j = NUM_REQ; j > 0; j--) begin
            if (req_valid[j-1]) begin
                if ((j - 1) > 32'(r_last)) begin
                    w_any_hi  = 1'b1;
                    w_pick_hi = GW'(j - 1);
                end else begin
                    w_pick_lo = GW'(j - 1);
                end
            end
        end
        w_pick = w_any_hi ? w_pick_hi : w_pick_lo;
    end

    assign w_last_byte = (r_cnt == CW'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        tx_start     = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_state_next = SEND;
                end
            end
            SEND: begin
                tx_start     = 1'b1;
                busy         = 1'b1;
                w_state_next = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (tx_done_tick) begin
                    w_state_next = w_last_byte ? IDLE : SEND;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_grant <= '0;
            r_last  <= GW'(NUM_REQ - 1);
            r_ack   <= '0;
            r_done  <= '0;
        end else begin
            r_ack  <= '0;
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    if (|req_valid) begin
                        r_shift        <= req_data[w_pick*W +: W];
                        r_cnt          <= '0;
                        r_grant        <= w_pick;
                        r_last         <= w_pick;
                        r_ack[w_pick]  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (tx_done_tick) begin
                        if (w_last_byte) begin
                            r_done[r_grant] <= 1'b1;
                        end else begin
                            r_shift <= r_shift >> DATA_BITS;
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_din    = r_shift[DATA_BITS-1:0];
    assign req_ack   = r_ack;
    assign word_done = r_done;
    assign grant_id  = r_grant;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a 2x4-byte instance with bench-driven done ticks,
// and a 1x2-byte instance driving a behavioural 8N1 UART transmitter (16 ticks per bit).
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [63:0] req_data;
    logic [1:0]  req_ack;
    logic [1:0]  word_done;
    logic [0:0]  grant_id;
    logic        busy;
    logic        tx_start;
    logic [7:0]  tx_din;
    logic        tx_done_tick;

    logic        r2_valid;
    logic [15:0] r2_data;
    logic        r2_ack;
    logic        r2_done;
    logic [0:0]  r2_gid;
    logic        r2_busy;
    logic        r2_start;
    logic [7:0]  r2_din;
    logic        u_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_ack = 0;
    int n_done = 0;
    int n_overlap = 0;
    int n_wide = 0;
    logic [1:0] prev_ack = '0;
    logic [1:0] prev_done = '0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.NUM_REQ(2), .DATA_BITS(8), .WORD_BYTES(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ack(req_ack), .word_done(word_done), .grant_id(grant_id), .busy(busy),
        .tx_start(tx_start), .tx_din(tx_din), .tx_done_tick(tx_done_tick)
    );

    uart_tx_scheduler #(.NUM_REQ(1), .DATA_BITS(8), .WORD_BYTES(2)) dut2 (
        .clk(clk), .reset(reset), .req_valid(r2_valid), .req_data(r2_data),
        .req_ack(r2_ack), .word_done(r2_done), .grant_id(r2_gid), .busy(r2_busy),
        .tx_start(r2_start), .tx_din(r2_din), .tx_done_tick(u_done)
    );

    // Behavioural UART TX: start bit, 8 data bits LSB first, stop bit; s_tick every cycle.
    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} ust_t;
    ust_t       us;
    logic [3:0] us_s;
    logic [2:0] us_n;
    logic [7:0] us_b;
    logic       u_tx;

    assign u_done = (us == U_STOP) && (us_s == 4'd15);

    always @(posedge clk) begin
        if (reset) begin
            us <= U_IDLE; us_s <= '0; us_n <= '0; us_b <= '0; u_tx <= 1'b1;
        end else begin
            case (us)
                U_IDLE: begin
                    u_tx <= 1'b1;
                    if (r2_start) begin us <= U_START; us_s <= '0; us_b <= r2_din; end
                end
                U_START: begin
                    u_tx <= 1'b0;
                    if (us_s == 4'd15) begin us <= U_DATA; us_s <= '0; us_n <= '0; end
                    else us_s <= us_s + 4'd1;
                end
                U_DATA: begin
                    u_tx <= us_b[0];
                    if (us_s == 4'd15) begin
                        us_s <= '0;
                        us_b <= us_b >> 1;
                        if (us_n == 3'd7) us <= U_STOP;
                        else us_n <= us_n + 3'd1;
                    end else us_s <= us_s + 4'd1;
                end
                default: begin
                    u_tx <= 1'b1;
                    if (us_s == 4'd15) us <= U_IDLE;
                    else us_s <= us_s + 4'd1;
                end
            endcase
        end
    end

    // Pulse monitor; at posedge it sees the registered outputs of the cycle just ended.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_ack != 0) n_ack <= n_ack + 1;
        if (word_done != 0) n_done <= n_done + 1;
        if (req_ack != 0 && word_done != 0) n_overlap <= n_overlap + 1;
        if ((req_ack & prev_ack) != 0 || (word_done & prev_done) != 0 ||
            $countones(req_ack) > 1 || $countones(word_done) > 1)
            n_wide <= n_wide + 1;
        prev_ack  <= req_ack;
        prev_done <= word_done;
    end

    function automatic logic [31:0] mk(input int r, input int w);
        logic [31:0] v;
        for (int k = 0; k < 4; k++) v[8*k +: 8] = 8'(r*64 + w*16 + k);
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1; req_valid = '0; tx_done_tick = 1'b0; r2_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_start(output int waited);
        waited = -1;
        for (int i = 0; i < 60; i++) begin
            if (tx_start) begin waited = i; break; end
            @(negedge clk);
        end
    endtask

    // Serves one byte: waits for tx_start, holds for 'hold' cycles, then pulses tx_done_tick.
    task automatic send_one(input int hold, output int waited, output logic [7:0] d0, output logic [7:0] d1);
        wait_start(waited);
        d0 = tx_din;
        repeat (hold) @(negedge clk);
        d1 = tx_din;
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
    endtask

    task automatic run_word(input logic [1:0] valid_after, input logic reload_en, input logic [31:0] reload_w,
                            output logic [0:0] g, output logic [1:0] ack, output logic [31:0] seen,
                            output int bad, output int ack_wait);
        int w;
        logic [7:0] d0, d1;
        bad = 0; ack_wait = -1; seen = '0;
        for (int i = 0; i < 60; i++) begin
            if (req_ack != 0) begin ack_wait = i; break; end
            @(negedge clk);
        end
        g = grant_id; ack = req_ack;
        req_valid = valid_after;
        if (reload_en) req_data[32*g +: 32] = reload_w;
        for (int k = 0; k < 4; k++) begin
            send_one(20, w, d0, d1);
            if (w != 0 || d0 != d1) bad++;
            seen[8*k +: 8] = d0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (req_ack !== 2'b00) begin errors++; $display("FAIL reset_ack got %b want 00", req_ack); end
        checks++; if (word_done !== 2'b00) begin errors++; $display("FAIL reset_done got %b want 00", word_done); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", tx_start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (tx_din !== 8'h00) begin errors++; $display("FAIL reset_din got %h want 00", tx_din); end
        checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_gid got %b want 0", grant_id); end
    endtask

    task automatic test_single_word();
        logic [0:0] g; logic [1:0] ack; logic [31:0] seen; int bad, aw, a0, dn0;
        req_data = {32'hDEADBEEF, 32'h44332211};
        a0 = n_ack; dn0 = n_done;
        req_valid = 2'b01;
        run_word(2'b00, 1'b0, '0, g, ack, seen, bad, aw);
        checks++; if (aw !== 1) begin errors++; $display("FAIL single_ackwait got %0d want 1", aw); end
        checks++; if (ack !== 2'b01) begin errors++; $display("FAIL single_ack got %b want 01", ack); end
        checks++; if (g !== 1'b0) begin errors++; $display("FAIL single_gid got %b want 0", g); end
        checks++; if (seen !== 32'h44332211) begin errors++; $display("FAIL single_bytes got %h want 44332211", seen); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL single_timing got %0d bad bytes want 0", bad); end
        checks++; if (word_done !== 2'b01) begin errors++; $display("FAIL single_done got %b want 01", word_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", busy); end
        @(negedge clk);
        checks++; if (word_done !== 2'b00) begin errors++; $display("FAIL single_done_width got %b want 00", word_done); end
        checks++; if (n_ack - a0 !== 1) begin errors++; $display("FAIL single_ack_count got %0d want 1", n_ack - a0); end
        checks++; if (n_done - dn0 !== 1) begin errors++; $display("FAIL single_done_count got %0d want 1", n_done - dn0); end
    endtask

    task automatic test_fairness();
        logic [0:0] g; logic [1:0] ack; logic [31:0] seen; int bad, aw, eg;
        logic [31:0] cur [2];
        do_reset();
        cur[0] = mk(0, 0); cur[1] = mk(1, 0);
        req_data = {cur[1], cur[0]};
        req_valid = 2'b11;
        for (int w = 0; w < 4; w++) begin
            eg = w % 2;
            run_word(2'b11, 1'b1, mk(eg, w + 1), g, ack, seen, bad, aw);
            checks++; if (g !== 1'(eg)) begin errors++; $display("FAIL fair_gid[%0d] got %0d want %0d", w, g, eg); end
            checks++; if (ack !== 2'(1 << eg)) begin errors++; $display("FAIL fair_ack[%0d] got %b want %b", w, ack, 2'(1 << eg)); end
            checks++; if (seen !== cur[eg]) begin errors++; $display("FAIL fair_bytes[%0d] got %h want %h", w, seen, cur[eg]); end
            checks++; if (bad !== 0 || aw !== 1) begin errors++; $display("FAIL fair_timing[%0d] got bad=%0d ackwait=%0d want 0/1", w, bad, aw); end
            cur[eg] = mk(eg, w + 1);
        end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_rotation();
        logic [0:0] g; logic [1:0] ack; logic [31:0] seen; int bad, aw;
        do_reset();
        req_data = {mk(1, 2), mk(0, 2)};
        req_valid = 2'b10;
        run_word(2'b00, 1'b0, '0, g, ack, seen, bad, aw);
        checks++; if (g !== 1'b1) begin errors++; $display("FAIL rot_req1_alone got %b want 1", g); end
        req_valid = 2'b11;
        run_word(2'b00, 1'b0, '0, g, ack, seen, bad, aw);
        checks++; if (g !== 1'b0) begin errors++; $display("FAIL rot_after_req1 got %b want 0", g); end
        req_valid = 2'b01;
        run_word(2'b00, 1'b0, '0, g, ack, seen, bad, aw);
        checks++; if (g !== 1'b0) begin errors++; $display("FAIL rot_req0_alone got %b want 0", g); end
        req_valid = 2'b11;
        run_word(2'b00, 1'b0, '0, g, ack, seen, bad, aw);
        checks++; if (g !== 1'b1) begin errors++; $display("FAIL rot_after_req0 got %b want 1", g); end
        checks++; if (seen !== mk(1, 2)) begin errors++; $display("FAIL rot_bytes got %h want %h", seen, mk(1, 2)); end
        @(negedge clk);
    endtask

    task automatic test_spurious_ticks();
        int w, dn0; logic [7:0] d0, d1; logic [31:0] seen;
        do_reset();
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || tx_start !== 1'b0) begin errors++; $display("FAIL spur_idle_state got busy=%b start=%b want 0/0", busy, tx_start); end
        checks++; if (tx_din !== 8'h00) begin errors++; $display("FAIL spur_idle_din got %h want 00", tx_din); end
        req_data = {32'h0, 32'h88776655};
        req_valid = 2'b01;
        dn0 = n_done;
        @(negedge clk);
        req_valid = 2'b00;
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        checks++; if (tx_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL spur_send_state got start=%b busy=%b want 0/1", tx_start, busy); end
        checks++; if (tx_din !== 8'h55) begin errors++; $display("FAIL spur_send_din got %h want 55", tx_din); end
        seen[7:0] = tx_din;
        repeat (18) @(negedge clk);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        for (int k = 1; k < 3; k++) begin
            send_one(20, w, d0, d1);
            seen[8*k +: 8] = d0;
        end
        checks++; if (word_done !== 2'b00 || tx_start !== 1'b1 || n_done != dn0) begin
            errors++; $display("FAIL spur_3ticks got done=%b start=%b ndone=%0d want 00/1/%0d", word_done, tx_start, n_done, dn0);
        end
        send_one(20, w, d0, d1);
        seen[31:24] = d0;
        checks++; if (word_done !== 2'b01) begin errors++; $display("FAIL spur_4ticks_done got %b want 01", word_done); end
        checks++; if (seen !== 32'h88776655) begin errors++; $display("FAIL spur_bytes got %h want 88776655", seen); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_word();
        logic [0:0] g; logic [1:0] ack; logic [31:0] seen; int bad, aw, w; logic [7:0] d0, d1;
        do_reset();
        req_data = {mk(1, 3), mk(0, 3)};
        req_valid = 2'b10;
        @(negedge clk);
        send_one(20, w, d0, d1);
        send_one(20, w, d0, d1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (req_ack !== 2'b00 || word_done !== 2'b00) begin errors++; $display("FAIL mid_rst_pulses got ack=%b done=%b want 00/00", req_ack, word_done); end
        checks++; if (tx_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_state got start=%b busy=%b want 0/0", tx_start, busy); end
        checks++; if (tx_din !== 8'h00 || grant_id !== 1'b0) begin errors++; $display("FAIL mid_rst_regs got din=%h gid=%b want 00/0", tx_din, grant_id); end
        run_word(2'b00, 1'b0, '0, g, ack, seen, bad, aw);
        checks++; if (g !== 1'b1 || seen !== mk(1, 3)) begin errors++; $display("FAIL mid_restart got gid=%b word=%h want 1/%h", g, seen, mk(1, 3)); end
        @(negedge clk);
        req_valid = 2'b10;
        @(negedge clk);
        send_one(20, w, d0, d1);
        reset = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        reset = 1'b0;
        run_word(2'b10, 1'b0, '0, g, ack, seen, bad, aw);
        checks++; if (g !== 1'b0) begin errors++; $display("FAIL mid_prio_req0 got %b want 0", g); end
        run_word(2'b00, 1'b0, '0, g, ack, seen, bad, aw);
        checks++; if (g !== 1'b1 || seen !== mk(1, 3) || aw !== 1) begin
            errors++; $display("FAIL mid_req1_after got gid=%b word=%h ackwait=%0d want 1/%h/1", g, seen, aw, mk(1, 3));
        end
        @(negedge clk);
    endtask

    task automatic test_integration();
        logic [7:0] exp_b [2];
        logic [7:0] got;
        logic sbit, pbit;
        int c0 [2];
        int found;
        exp_b[0] = 8'h5A; exp_b[1] = 8'hA5;
        do_reset();
        r2_data = 16'hA55A;
        r2_valid = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (r2_ack) begin found = 1; break; end
        end
        r2_valid = 1'b0;
        checks++; if (found != 1) begin errors++; $display("FAIL int_ack got none want ack"); end
        for (int f = 0; f < 2; f++) begin
            found = 0;
            for (int i = 0; i < 400; i++) begin
                if (u_tx === 1'b0) begin found = 1; break; end
                @(negedge clk);
            end
            c0[f] = cyc;
            repeat (8) @(negedge clk);
            sbit = u_tx;
            for (int k = 0; k < 8; k++) begin
                repeat (16) @(negedge clk);
                got[k] = u_tx;
            end
            repeat (16) @(negedge clk);
            pbit = u_tx;
            checks++; if (found != 1 || sbit !== 1'b0) begin errors++; $display("FAIL int_start[%0d] got found=%0d bit=%b want 1/0", f, found, sbit); end
            checks++; if (got !== exp_b[f]) begin errors++; $display("FAIL int_frame[%0d] got %h want %h", f, got, exp_b[f]); end
            checks++; if (pbit !== 1'b1) begin errors++; $display("FAIL int_stop[%0d] got %b want 1", f, pbit); end
        end
        checks++; if (c0[1] - c0[0] !== 161) begin errors++; $display("FAIL int_frame_spacing got %0d want 161", c0[1] - c0[0]); end
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (r2_done) begin found = 1; break; end
            @(negedge clk);
        end
        checks++; if (found != 1) begin errors++; $display("FAIL int_word_done got none want pulse"); end
    endtask

    task automatic test_pulse_rules();
        checks++; if (n_overlap !== 0) begin errors++; $display("FAIL pulse_overlap got %0d want 0", n_overlap); end
        checks++; if (n_wide !== 0) begin errors++; $display("FAIL pulse_width got %0d want 0", n_wide); end
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_data = '0; tx_done_tick = 1'b0;
        r2_valid = 1'b0; r2_data = '0;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_fairness();
        test_rotation();
        test_spurious_ticks();
        test_reset_mid_word();
        test_integration();
        test_pulse_rules();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

endmodule
